// File: rtl/ft_tx_engine.sv
// FPGA-to-USB transmit engine for the FT232H in FT245 synchronous FIFO mode.
// Streams either a block of 16-bit memory words (MSB byte first) or a snapshot
// of the debug registers over the FT232H data bus under TXE_N/WR_N handshake.
// Optional build macro FT_TX_HEADER_EN: prefix each transfer with a 3-byte
// header (A5/5A marker, then 16-bit payload length, hi byte first).
module ft_tx_engine #(
  parameter int unsigned REG_COUNT = 8
) (
  input  logic        FT_CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        MODE,
  input  logic [31:0] START_ADDR,
  input  logic [15:0] BYTE_COUNT,
  output logic        MEM_RD_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_RD_ACK,
  input  logic [15:0] MEM_DI,
  input  logic [31:0] REG_IN_0,
  input  logic [31:0] REG_IN_1,
  input  logic [31:0] REG_IN_2,
  input  logic [31:0] REG_IN_3,
  input  logic [31:0] REG_IN_4,
  input  logic [31:0] REG_IN_5,
  input  logic [31:0] REG_IN_6,
  input  logic [31:0] REG_IN_7,
  input  logic        TXE_N,
  output logic        WR_N,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_OE,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StSendHi, StSendLo, StReg, StFin, StDone, StHdr
  } state_e;

  localparam logic [4:0] LastIdx = 5'(4 * REG_COUNT - 1);

  state_e      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  lo_q, lo_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] snap_q [8];
  logic [31:0] snap_d [8];
  logic        wr_n_q, wr_n_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic        req_q, req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef FT_TX_HEADER_EN
  localparam logic [15:0] RegLen = 16'(4 * REG_COUNT);
  logic        mode_q, mode_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] len_q, len_d;
`endif

  logic [31:0] reg_in [8];
  logic        accept;
  logic [4:0]  idx_nx;
  logic [31:0] reg_word;
  logic [7:0]  reg_byte;

  assign reg_in[0] = REG_IN_0;
  assign reg_in[1] = REG_IN_1;
  assign reg_in[2] = REG_IN_2;
  assign reg_in[3] = REG_IN_3;
  assign reg_in[4] = REG_IN_4;
  assign reg_in[5] = REG_IN_5;
  assign reg_in[6] = REG_IN_6;
  assign reg_in[7] = REG_IN_7;

  assign MEM_RD_REQ = req_q;
  assign MEM_ADDR   = mem_addr_q;
  assign WR_N       = wr_n_q;
  assign DATA_OUT   = data_out_q;
  assign DATA_OE    = data_oe_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    lo_d       = lo_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    wr_n_d     = wr_n_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    req_d      = req_q;
    mem_addr_d = mem_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef FT_TX_HEADER_EN
    mode_d     = mode_q;
    hdr_idx_d  = hdr_idx_q;
    len_d      = len_q;
`endif
    accept   = !wr_n_q && !TXE_N;
    idx_nx   = idx_q + 5'd1;
    reg_word = snap_q[idx_nx[4:2]];
    unique case (idx_nx[1:0])
      2'd0:    reg_byte = reg_word[31:24];
      2'd1:    reg_byte = reg_word[23:16];
      2'd2:    reg_byte = reg_word[15:8];
      default: reg_byte = reg_word[7:0];
    endcase

    case (state_q)
      StIdle: begin
        if (START && !busy_q) begin
          busy_d     = 1'b1;
          data_oe_d  = 1'b1;
          rem_d      = BYTE_COUNT;
          mem_addr_d = START_ADDR;
          idx_d      = 5'd0;
          for (int i = 0; i < 8; i++) snap_d[i] = reg_in[i];
`ifdef FT_TX_HEADER_EN
          mode_d     = MODE;
          hdr_idx_d  = 2'd0;
          len_d      = MODE ? RegLen : BYTE_COUNT;
          wr_n_d     = 1'b0;
          data_out_d = MODE ? 8'h5A : 8'hA5;
          state_d    = StHdr;
`else
          if (MODE) begin
            wr_n_d     = 1'b0;
            data_out_d = REG_IN_0[31:24];
            state_d    = StReg;
          end else if (BYTE_COUNT == 16'd0) begin
            state_d = StFin;
          end else begin
            req_d   = 1'b1;
            state_d = StFetch;
          end
`endif
        end
      end
`ifdef FT_TX_HEADER_EN
      StHdr: begin
        if (accept) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd0) begin
            data_out_d = len_q[15:8];
          end else if (hdr_idx_q == 2'd1) begin
            data_out_d = len_q[7:0];
          end else if (mode_q) begin
            data_out_d = snap_q[0][31:24];
            state_d    = StReg;
          end else if (rem_q == 16'd0) begin
            wr_n_d  = 1'b1;
            state_d = StFin;
          end else begin
            wr_n_d  = 1'b1;
            req_d   = 1'b1;
            state_d = StFetch;
          end
        end
      end
`endif
      StFetch: begin
        if (MEM_RD_ACK) begin
          req_d      = 1'b0;
          lo_d       = MEM_DI[7:0];
          wr_n_d     = 1'b0;
          data_out_d = MEM_DI[15:8];
          state_d    = StSendHi;
        end
      end
      StSendHi: begin
        if (accept) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            wr_n_d  = 1'b1;
            state_d = StFin;
          end else begin
            data_out_d = lo_q;
            state_d    = StSendLo;
          end
        end
      end
      StSendLo: begin
        if (accept) begin
          rem_d      = rem_q - 16'd1;
          mem_addr_d = mem_addr_q + 32'd2;
          wr_n_d     = 1'b1;
          if (rem_q == 16'd1) begin
            state_d = StFin;
          end else begin
            req_d   = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StReg: begin
        if (accept) begin
          if (idx_q == LastIdx) begin
            wr_n_d  = 1'b1;
            state_d = StFin;
          end else begin
            idx_d      = idx_nx;
            data_out_d = reg_byte;
          end
        end
      end
      StFin: begin
        done_d    = 1'b1;
        data_oe_d = 1'b0;
        state_d   = StDone;
      end
      StDone: begin
        // BUSY stays high through the DONE cycle so a coincident START is ignored
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge FT_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      lo_q       <= '0;
      idx_q      <= '0;
      for (int i = 0; i < 8; i++) snap_q[i] <= '0;
      wr_n_q     <= 1'b1;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      req_q      <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FT_TX_HEADER_EN
      mode_q     <= 1'b0;
      hdr_idx_q  <= '0;
      len_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      lo_q       <= lo_d;
      idx_q      <= idx_d;
      for (int i = 0; i < 8; i++) snap_q[i] <= snap_d[i];
      wr_n_q     <= wr_n_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      req_q      <= req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef FT_TX_HEADER_EN
      mode_q     <= mode_d;
      hdr_idx_q  <= hdr_idx_d;
      len_q      <= len_d;
`endif
    end
  end

endmodule

// File: doc/ft_tx_engine.md
Name: ft_tx_engine

Overview:
- FPGA-to-USB transmit engine for the FT232H in FT245 synchronous FIFO mode. It is the counterpart of the USB-to-FPGA command receiver and services the read command (CMD 0x00).
- On a START pulse it streams either a block of 16-bit words fetched from the design bus, or a snapshot of the eight 32-bit debug registers, out over the FT232H data bus under TXE_N/WR_N flow control.
- The top level owns the ADBUS tristate, using DATA_OUT and DATA_OE.

Parameters:
- REG_COUNT, 8, number of REG_IN words sent in register-dump mode (1..8).

Ports:
- FT_CLK  input  1  60 MHz clock from the FT232H; the only clock.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle request pulse; ignored while BUSY=1.
- MODE  input  1  sampled with START: 0 = memory block, 1 = register dump.
- START_ADDR  input  32  first byte address (even) for memory mode.
- BYTE_COUNT  input  16  bytes to send in memory mode.
- MEM_RD_REQ  output  1  word read request; held high until MEM_RD_ACK.
- MEM_ADDR  output  32  word address for the current request.
- MEM_RD_ACK  input  1  one-cycle acknowledge; MEM_DI is valid in the same cycle.
- MEM_DI  input  16  read data; [15:8] is sent first.
- REG_IN_0..REG_IN_7  input  32 each  debug registers for dump mode.
- TXE_N  input  1  low = FT232H TX FIFO can accept a byte.
- WR_N  output  1  low = DATA_OUT is offered for write.
- DATA_OUT  output  8  byte presented to ADBUS.
- DATA_OE  output  1  top level drives ADBUS from DATA_OUT while high.
- BUSY  output  1  high from the cycle after an accepted START until DONE; the receiver keeps OE_N high while BUSY=1.
- DONE  output  1  one-cycle pulse when the last byte has been accepted.

Behaviour:
- Reset values: WR_N=1, DATA_OE=0, MEM_RD_REQ=0, BUSY=0, DONE=0, DATA_OUT=0x00, MEM_ADDR=0. Reset mid-transfer abandons the transfer immediately; no partial byte is retried after reset.
- All outputs are registered.
- Byte acceptance: a byte is accepted at a rising FT_CLK edge where WR_N==0 and TXE_N==0.
  - While TXE_N is high, WR_N stays low and DATA_OUT is held unchanged until accepted.
  - On acceptance, the next byte (if buffered) is loaded at the same edge, giving back-to-back bytes at 60 MB/s. Otherwise WR_N returns to 1 at that edge.
- DATA_OE rises at the START-accept edge and falls at the edge DONE is asserted.
- States:
  - IDLE: on START with BUSY=0, latch MODE, START_ADDR, BYTE_COUNT; set BUSY.
    - MODE=0 and BYTE_COUNT=0: go to FIN.
    - MODE=0 otherwise: go to FETCH.
    - MODE=1: go to REG.
  - FETCH: MEM_RD_REQ=1, MEM_ADDR=current address. On MEM_RD_ACK, latch MEM_DI, deassert REQ, go to SEND_HI.
  - SEND_HI: present word[15:8]. On accept: remaining-=1; if remaining==0 go to FIN, else go to SEND_LO.
  - SEND_LO: present word[7:0]. On accept: remaining-=1, address+=2; if remaining==0 go to FIN, else go to FETCH.
  - REG: send REG_IN_0..REG_IN_(REG_COUNT-1), each MSB byte first, 4*REG_COUNT bytes total. All registers are snapshotted at the START-accept edge, so later REG_IN changes do not affect the sent data. After the last accept, go to FIN.
  - FIN: WR_N=1, DONE=1 for one cycle, BUSY=0, return to IDLE.
- Odd BYTE_COUNT: the low byte of the final word is fetched but not sent.
- Address arithmetic is 32-bit and wraps from 0xFFFFFFFE to 0x00000000. The remaining-byte counter is 16-bit and never underflows.
- START coincident with DONE is ignored, because BUSY is still high in that cycle.
- Zero-latency MEM_RD_ACK (ACK in the first REQ cycle) is legal.
- One buffered word only; no prefetch. A one-cycle WR_N gap between words is permitted.

Optional Feature:
- FT_TX_HEADER_EN.
- Defined: every transfer is preceded by 3 header bytes.
  - Byte 1: 0xA5 (memory mode) or 0x5A (dump mode).
  - Bytes 2-3: payload length hi, then lo (BYTE_COUNT, or 4*REG_COUNT).
  - A zero-length memory transfer still sends A5 00 00.
  - Header bytes obey the same TXE_N flow control.
- Undefined: payload only, and zero-length memory transfers emit no bytes.

Test Plan:
- Memory mode, START_ADDR=0x100, BYTE_COUNT=4, memory returns 0x1234 then 0xABCD, TXE_N=0 throughout -> MEM_ADDR 0x100 then 0x102; bytes 12 34 AB CD; one DONE pulse; BUSY low afterwards.
- Same request with TXE_N held high for 5 cycles while 0x34 is presented -> WR_N stays low, DATA_OUT holds 0x34, no duplicate or lost byte.
- BYTE_COUNT=3, memory data 0x0102, 0x0304 -> bytes 01 02 03 only; two fetches.
- MODE=1 with REG_IN_0=0xDEADBEEF and REG_IN_1..7=0; REG_IN_0 changes after START -> 32 bytes starting DE AD BE EF, reflecting the snapshot.
- RESET_N pulsed low during SEND_LO -> WR_N=1, DATA_OE=0, BUSY=0 asynchronously; a new START afterwards completes normally.
- BYTE_COUNT=0 -> DONE one cycle after IDLE exit, no WR_N activity (with FT_TX_HEADER_EN: exactly A5 00 00). A START issued while BUSY=1 is ignored.
